// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the 23K640 SRAM round-robin arbiter.
package sram_arb_pkg;

    localparam int c_addr_w = 16;
    localparam int c_data_w = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side and controller-side bus of the SRAM arbiter.
// The master modport is the arbiter's view; slave is the environment's.
interface sram_rr_arbiter_if #(
    parameter int p_reqs = 4
);
    import sram_arb_pkg::*;

    logic [p_reqs-1:0]          i_req_valid;
    logic [p_reqs-1:0]          i_req_rd_n_wr;
    logic [c_addr_w*p_reqs-1:0] i_req_addr;
    logic [c_data_w*p_reqs-1:0] i_req_wdata;
    logic [p_reqs-1:0]          o_req_accept;
    logic [p_reqs-1:0]          o_req_ready;
    logic [c_data_w-1:0]        o_req_rdata;

    logic                       o_valid;
    logic                       i_accept;
    logic                       o_rd_n_wr;
    logic [c_addr_w-1:0]        o_addr;
    logic [c_data_w-1:0]        o_wdata;
    logic                       i_ready;
    logic [c_data_w-1:0]        i_rdata;

    modport master (
        input  i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
        output o_req_accept, o_req_ready, o_req_rdata,
        output o_valid, o_rd_n_wr, o_addr, o_wdata,
        input  i_accept, i_ready, i_rdata
    );

    modport slave (
        output i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
        input  o_req_accept, o_req_ready, o_req_rdata,
        input  o_valid, o_rd_n_wr, o_addr, o_wdata,
        output i_accept, i_ready, i_rdata
    );

endinterface

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr,
// wrapping to 0, using a doubled request vector with the low part masked.
module rr_pick #(
    parameter int p_reqs  = 4,
    parameter int p_idx_w = $clog2(p_reqs)
) (
    input  logic [p_reqs-1:0]  req,
    input  logic [p_idx_w-1:0] ptr,
    output logic               found,
    output logic [p_idx_w-1:0] idx
);

    localparam logic [2*p_reqs-1:0] c_one = 1;

    logic [2*p_reqs-1:0] dbl;
    logic [2*p_reqs-1:0] masked;
    int                  hit;

    // Upper copy is never masked, so any set request is always found.
    always_comb begin
        dbl    = {req, req};
        masked = dbl & ~((c_one << ptr) - c_one);
        found  = |req;
        hit    = 0;
        for (int i = 2*p_reqs-1; i >= 0; i--) begin
            if (masked[i]) begin
                hit = i;
            end
        end
        idx = (hit >= p_reqs) ? p_idx_w'(hit - p_reqs) : p_idx_w'(hit);
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin sharing of one 23K640 SPI SRAM controller port between
// p_reqs requesters, with a sticky protocol/timeout error flag.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int p_reqs    = 4,
    parameter int p_idx_w   = $clog2(p_reqs),
    parameter int p_timeout = 1023
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sram_rr_arbiter_if.master  bus,
    output logic [p_idx_w-1:0] o_grant,
    output logic               o_busy,
    output logic               o_err
);

    localparam int c_cnt_w = $clog2(p_timeout + 1);

    arb_state_t           state;
    logic [p_idx_w-1:0]   ptr;
    logic [p_idx_w-1:0]   grant;
    logic                 rd_n_wr_q;
    logic [c_addr_w-1:0]  addr_q;
    logic [c_data_w-1:0]  wdata_q;
    logic [c_data_w-1:0]  rdata_q;
    logic [c_cnt_w-1:0]   cnt;

    logic                 found;
    logic [p_idx_w-1:0]   winner;
    logic                 accept_hit;
    logic                 done;
    logic                 proto_err;

    rr_pick #(
        .p_reqs  (p_reqs),
        .p_idx_w (p_idx_w)
    ) u_pick (
        .req   (bus.i_req_valid),
        .ptr   (ptr),
        .found (found),
        .idx   (winner)
    );

    assign accept_hit = (state == ISSUE) && bus.i_accept;
    assign done       = (state == WAIT)  && bus.i_ready;

    // Controller handshakes out of phase, or a requester withdrawing mid-issue.
    always_comb begin
        proto_err = 1'b0;
        if (bus.i_accept && (state != ISSUE)) begin
            proto_err = 1'b1;
        end
        if (bus.i_ready && (state != WAIT)) begin
            proto_err = 1'b1;
        end
        if ((state == ISSUE) && !bus.i_req_valid[grant]) begin
            proto_err = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            rd_n_wr_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            o_err     <= 1'b0;
        end else begin
            if (proto_err) begin
                o_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= winner;
                        rd_n_wr_q <= bus.i_req_rd_n_wr[winner];
                        addr_q    <= bus.i_req_addr[winner*c_addr_w +: c_addr_w];
                        wdata_q   <= bus.i_req_wdata[winner*c_data_w +: c_data_w];
                        ptr       <= (winner == p_idx_w'(p_reqs - 1)) ? '0 : winner + 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.i_accept) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_ready) begin
                        rdata_q <= bus.i_rdata;
                        state   <= IDLE;
                    end else if (cnt == c_cnt_w'(p_timeout - 1)) begin
                        cnt   <= cnt + 1'b1;
                        o_err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion pulses follow the controller handshakes in the same cycle.
    always_comb begin
        bus.o_req_accept = '0;
        bus.o_req_ready  = '0;
        if (accept_hit) begin
            bus.o_req_accept[grant] = 1'b1;
        end
        if (done) begin
            bus.o_req_ready[grant] = 1'b1;
        end
    end

    assign bus.o_req_rdata = done ? bus.i_rdata : rdata_q;
    assign bus.o_valid     = (state == ISSUE);
    assign bus.o_rd_n_wr   = rd_n_wr_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_wdata     = wdata_q;
    assign o_grant         = grant;
    assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: reset, single read, fairness, wrap,
// write, timeout, protocol errors and reset mid-transaction.
module tb_sram_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] o_grant;
    logic       o_busy;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    sram_rr_arbiter_if #(.p_reqs(4)) bus ();

    sram_rr_arbiter #(
        .p_reqs    (4),
        .p_idx_w   (2),
        .p_timeout (15)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_grant (o_grant),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic v, input logic rd,
                                 input logic [15:0] addr, input logic [7:0] wd);
        bus.i_req_valid[k]           = v;
        bus.i_req_rd_n_wr[k]         = rd;
        bus.i_req_addr[16*k +: 16]   = addr;
        bus.i_req_wdata[8*k +: 8]    = wd;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Starts in an IDLE cycle with requests set; ends in the following IDLE cycle.
    task automatic runTxn(input string tag, input int g, input logic rd, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] rdv, input bit drop);
        tick();
        checkOutput($sformatf("%s.grant", tag), 32'(o_grant), 32'(g));
        checkOutput($sformatf("%s.valid", tag), 32'(bus.o_valid), 32'd1);
        checkOutput($sformatf("%s.rd_n_wr", tag), 32'(bus.o_rd_n_wr), 32'(rd));
        checkOutput($sformatf("%s.addr", tag), 32'(bus.o_addr), 32'(addr));
        checkOutput($sformatf("%s.wdata", tag), 32'(bus.o_wdata), 32'(wd));
        bus.i_accept = 1'b1;
        #1;
        checkOutput($sformatf("%s.accept", tag), 32'(bus.o_req_accept), 32'd1 << g);
        checkOutput($sformatf("%s.ready_early", tag), 32'(bus.o_req_ready), 32'd0);
        tick();
        bus.i_accept = 1'b0;
        if (drop) begin
            bus.i_req_valid[g] = 1'b0;
        end
        bus.i_ready = 1'b1;
        bus.i_rdata = rdv;
        #1;
        checkOutput($sformatf("%s.ready", tag), 32'(bus.o_req_ready), 32'd1 << g);
        checkOutput($sformatf("%s.rdata", tag), 32'(bus.o_req_rdata), 32'(rdv));
        tick();
        bus.i_ready = 1'b0;
        bus.i_rdata = 8'h00;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_req_valid   = '0;
        bus.i_req_rd_n_wr = '0;
        bus.i_req_addr    = '0;
        bus.i_req_wdata   = '0;
        bus.i_accept      = 1'b0;
        bus.i_ready       = 1'b0;
        bus.i_rdata       = 8'h00;

        tick();
        tick();
        checkOutput("rst.valid", 32'(bus.o_valid), 32'd0);
        checkOutput("rst.busy", 32'(o_busy), 32'd0);
        checkOutput("rst.err", 32'(o_err), 32'd0);
        checkOutput("rst.grant", 32'(o_grant), 32'd0);
        checkOutput("rst.rdata", 32'(bus.o_req_rdata), 32'd0);
        checkOutput("rst.addr", 32'(bus.o_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] fairness");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k, 1'b1, 1'b1, 16'h1000 + 16'(k), 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            runTxn($sformatf("fair%0d", i), i % 4, 1'b1, 16'h1000 + 16'(i % 4), 8'h00,
                   8'h10 + 8'(i), 1'b0);
        end
        bus.i_req_valid = '0;

        $display("[TB] single read");
        applyStimulus(1, 1'b1, 1'b1, 16'h1234, 8'h00);
        #1;
        checkOutput("rd.valid_t", 32'(bus.o_valid), 32'd0);
        tick();
        checkOutput("rd.valid_t1", 32'(bus.o_valid), 32'd1);
        checkOutput("rd.addr", 32'(bus.o_addr), 32'h1234);
        checkOutput("rd.rd_n_wr", 32'(bus.o_rd_n_wr), 32'd1);
        checkOutput("rd.grant", 32'(o_grant), 32'd1);
        tick();
        checkOutput("rd.valid_hold", 32'(bus.o_valid), 32'd1);
        checkOutput("rd.no_accept", 32'(bus.o_req_accept), 32'd0);
        tick();
        bus.i_accept = 1'b1;
        #1;
        checkOutput("rd.accept", 32'(bus.o_req_accept), 32'h2);
        tick();
        bus.i_accept = 1'b0;
        bus.i_req_valid[1] = 1'b0;
        #1;
        checkOutput("rd.valid_wait", 32'(bus.o_valid), 32'd0);
        checkOutput("rd.busy_wait", 32'(o_busy), 32'd1);
        tick();
        tick();
        bus.i_ready = 1'b1;
        bus.i_rdata = 8'hA5;
        #1;
        checkOutput("rd.ready", 32'(bus.o_req_ready), 32'h2);
        checkOutput("rd.rdata", 32'(bus.o_req_rdata), 32'hA5);
        tick();
        bus.i_ready = 1'b0;
        bus.i_rdata = 8'h00;
        #1;
        checkOutput("rd.ready_off", 32'(bus.o_req_ready), 32'd0);
        checkOutput("rd.rdata_hold", 32'(bus.o_req_rdata), 32'hA5);
        checkOutput("rd.busy_end", 32'(o_busy), 32'd0);
        checkOutput("rd.err", 32'(o_err), 32'd0);

        $display("[TB] wrap");
        applyStimulus(2, 1'b1, 1'b1, 16'h0200, 8'h00);
        runTxn("wrapA2", 2, 1'b1, 16'h0200, 8'h00, 8'h21, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 16'h0000, 8'h00);
        runTxn("wrapA0", 0, 1'b1, 16'h0000, 8'h00, 8'h22, 1'b1);
        applyStimulus(2, 1'b1, 1'b1, 16'h0202, 8'h00);
        runTxn("wrapB2", 2, 1'b1, 16'h0202, 8'h00, 8'h23, 1'b1);
        applyStimulus(1, 1'b1, 1'b1, 16'h0101, 8'h00);
        applyStimulus(3, 1'b1, 1'b1, 16'h0303, 8'h00);
        runTxn("wrapB3", 3, 1'b1, 16'h0303, 8'h00, 8'h24, 1'b1);
        runTxn("wrapB1", 1, 1'b1, 16'h0101, 8'h00, 8'h25, 1'b1);
        applyStimulus(3, 1'b1, 1'b1, 16'h0333, 8'h00);
        runTxn("wrapC3", 3, 1'b1, 16'h0333, 8'h00, 8'h26, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 8'h00);
        runTxn("wrapC0", 0, 1'b1, 16'h0010, 8'h00, 8'h27, 1'b1);

        $display("[TB] write");
        applyStimulus(2, 1'b1, 1'b0, 16'h1FFF, 8'h5A);
        runTxn("write", 2, 1'b0, 16'h1FFF, 8'h5A, 8'h3C, 1'b1);
        checkOutput("write.err", 32'(o_err), 32'd0);

        $display("[TB] timeout");
        applyStimulus(0, 1'b1, 1'b1, 16'h0042, 8'h00);
        tick();
        checkOutput("to.grant", 32'(o_grant), 32'd0);
        bus.i_accept = 1'b1;
        #1;
        checkOutput("to.accept", 32'(bus.o_req_accept), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 1) begin
                bus.i_accept = 1'b0;
                bus.i_req_valid[0] = 1'b0;
            end
        end
        checkOutput("to.err_15", 32'(o_err), 32'd0);
        checkOutput("to.busy_15", 32'(o_busy), 32'd1);
        tick();
        checkOutput("to.err_16", 32'(o_err), 32'd1);
        checkOutput("to.busy_16", 32'(o_busy), 32'd0);
        checkOutput("to.no_ready", 32'(bus.o_req_ready), 32'd0);
        applyStimulus(3, 1'b1, 1'b0, 16'hFFFF, 8'hC3);
        runTxn("after_to", 3, 1'b0, 16'hFFFF, 8'hC3, 8'h00, 1'b1);
        checkOutput("after_to.err_sticky", 32'(o_err), 32'd1);

        $display("[TB] protocol");
        doReset();
        checkOutput("rst2.err", 32'(o_err), 32'd0);
        bus.i_ready = 1'b1;
        bus.i_rdata = 8'h77;
        #1;
        checkOutput("idle_ready.ready", 32'(bus.o_req_ready), 32'd0);
        checkOutput("idle_ready.rdata", 32'(bus.o_req_rdata), 32'd0);
        tick();
        bus.i_ready = 1'b0;
        bus.i_rdata = 8'h00;
        checkOutput("idle_ready.err", 32'(o_err), 32'd1);
        doReset();
        bus.i_accept = 1'b1;
        #1;
        checkOutput("idle_accept.accept", 32'(bus.o_req_accept), 32'd0);
        tick();
        bus.i_accept = 1'b0;
        checkOutput("idle_accept.err", 32'(o_err), 32'd1);
        checkOutput("idle_accept.busy", 32'(o_busy), 32'd0);

        $display("[TB] reset mid-transaction");
        applyStimulus(1, 1'b1, 1'b1, 16'h0ABC, 8'h00);
        tick();
        bus.i_accept = 1'b1;
        tick();
        bus.i_accept = 1'b0;
        bus.i_req_valid[1] = 1'b0;
        #1;
        checkOutput("midrst.busy_before", 32'(o_busy), 32'd1);
        checkOutput("midrst.grant_before", 32'(o_grant), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.valid", 32'(bus.o_valid), 32'd0);
        checkOutput("midrst.busy", 32'(o_busy), 32'd0);
        checkOutput("midrst.grant", 32'(o_grant), 32'd0);
        checkOutput("midrst.addr", 32'(bus.o_addr), 32'd0);
        checkOutput("midrst.rd_n_wr", 32'(bus.o_rd_n_wr), 32'd0);
        checkOutput("midrst.err", 32'(o_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
